ex_muldiv_unit: RTL and testbench

//  Execute-stage RV32M multiply/divide unit; consumes ID/IE outputs (fnc3, Ra/Rb, Rd, AluMulSel).

---
 rtl/ex_pkg.sv | 22 ++
 rtl/ex_muldiv_datapath.sv | 44 ++++
 rtl/ex_muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the RV32M execute-stage multiply/divide unit:
// fnc3 opcodes, FSM state encoding and the default operand width.
package ex_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] MULDIV_MUL    = 3'b000;
  localparam logic [2:0] MULDIV_MULH   = 3'b001;
  localparam logic [2:0] MULDIV_MULHSU = 3'b010;
  localparam logic [2:0] MULDIV_MULHU  = 3'b011;
  localparam logic [2:0] MULDIV_DIV    = 3'b100;
  localparam logic [2:0] MULDIV_DIVU   = 3'b101;
  localparam logic [2:0] MULDIV_REM    = 3'b110;
  localparam logic [2:0] MULDIV_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ex_muldiv_datapath.sv
// One radix-2 iteration on magnitudes: shift-add multiply step or
// restoring-divide step. Purely combinational; state lives in the top.
module ex_muldiv_datapath #(
  parameter int XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] m_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    acc_o   = acc_i;
    lo_o    = lo_i;
    sum     = '0;
    shifted = '0;
    diff    = '0;
    if (is_div_i) begin
      // acc = partial remainder, lo = dividend shifting out / quotient shifting in
      shifted = {acc_i, lo_i[XLEN-1]};
      diff    = shifted - {1'b0, m_i};
      if (diff[XLEN]) begin
        acc_o = shifted[XLEN-1:0];
        lo_o  = {lo_i[XLEN-2:0], 1'b0};
      end else begin
        acc_o = diff[XLEN-1:0];
        lo_o  = {lo_i[XLEN-2:0], 1'b1};
      end
    end else begin
      // {acc, lo} is the 2*XLEN product register; lo starts as the multiplier
      sum   = {1'b0, acc_i} + (lo_i[0] ? {1'b0, m_i} : '0);
      acc_o = sum[XLEN:1];
      lo_o  = {sum[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M iterative multiply/divide unit with ID/IE stall handshake.
// Optional build macro FAST_MUL_EN: single-cycle MUL* using one '*'.
module ex_muldiv_unit
  import ex_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      fnc3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic [4:0]      rd_i,
  input  logic            kill_i,
  output logic            stall_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        fnc3_q;
  logic [4:0]        rd_q, rd_out_q;
  logic              neg_q;
  logic [XLEN-1:0]   m_q, acc_q, lo_q, result_q;

  logic              acc_is_div, signed_a, signed_b, a_neg, b_neg, acc_neg;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              special, direct_mul, direct;
  logic [XLEN-1:0]   special_res, direct_res;
  logic              accept, last_iter;
  logic [XLEN-1:0]   step_acc, step_lo;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, calc_res;

  // Operand conditioning for the op presented in the accept cycle
  assign acc_is_div = fnc3_i[2];
  assign signed_a   = (fnc3_i != MULDIV_MULHU) && (fnc3_i != MULDIV_DIVU) &&
                      (fnc3_i != MULDIV_REMU);
  assign signed_b   = signed_a && (fnc3_i != MULDIV_MULHSU);
  assign a_neg      = signed_a & op_a_i[XLEN-1];
  assign b_neg      = signed_b & op_b_i[XLEN-1];
  assign abs_a      = a_neg ? -op_a_i : op_a_i;
  assign abs_b      = b_neg ? -op_b_i : op_b_i;
  // Remainder takes the dividend's sign; quotient and product take the xor
  assign acc_neg    = (acc_is_div && fnc3_i[1]) ? a_neg : (a_neg ^ b_neg);

  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (acc_is_div && (op_b_i == '0)) begin
      special     = 1'b1;
      special_res = fnc3_i[1] ? op_a_i : '1;
    end else if (acc_is_div && !fnc3_i[0] && (op_a_i == MinInt) && (op_b_i == '1)) begin
      special     = 1'b1;
      special_res = fnc3_i[1] ? '0 : MinInt;
    end
  end

`ifdef FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod, fast_fix;
  assign fast_prod  = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
  assign fast_fix   = acc_neg ? -fast_prod : fast_prod;
  assign direct_mul = ~acc_is_div;
  assign direct_res = acc_is_div ? special_res :
                      (fnc3_i == MULDIV_MUL) ? fast_fix[XLEN-1:0] : fast_fix[2*XLEN-1:XLEN];
`else
  assign direct_mul = 1'b0;
  assign direct_res = special_res;
`endif

  assign direct    = special | direct_mul;
  assign accept    = (state_q == ST_IDLE) && start_i && !kill_i;
  assign last_iter = (state_q == ST_CALC) && (cnt_q == CNT_W'(XLEN-1));

  ex_muldiv_datapath #(.XLEN(XLEN)) u_datapath (
    .is_div_i (fnc3_q[2]),
    .acc_i    (acc_q),
    .lo_i     (lo_q),
    .m_i      (m_q),
    .acc_o    (step_acc),
    .lo_o     (step_lo)
  );

  // Sign fix and width selection applied to the final iteration's output
  assign prod_fix = neg_q ? -{step_acc, step_lo} : {step_acc, step_lo};
  assign quo_fix  = neg_q ? -step_lo  : step_lo;
  assign rem_fix  = neg_q ? -step_acc : step_acc;
  assign calc_res = fnc3_q[2] ? (fnc3_q[1] ? rem_fix : quo_fix) :
                    (fnc3_q == MULDIV_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (kill_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (start_i) state_d = direct ? ST_DONE : ST_CALC;
        ST_CALC: if (last_iter) state_d = ST_DONE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    stall_o        = 1'b0;
    result_valid_o = 1'b0;
    if (!kill_i) begin
      stall_o        = ((state_q == ST_IDLE) && start_i) || (state_q == ST_CALC);
      result_valid_o = (state_q == ST_DONE);
    end
  end

  assign result_o = result_q;
  assign rd_o     = rd_out_q;

  // Operand capture, iteration registers and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      fnc3_q   <= '0;
      rd_q     <= '0;
      rd_out_q <= '0;
      neg_q    <= 1'b0;
      m_q      <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else if (accept) begin
      cnt_q  <= '0;
      fnc3_q <= fnc3_i;
      rd_q   <= rd_i;
      neg_q  <= acc_neg;
      acc_q  <= '0;
      m_q    <= acc_is_div ? abs_b : abs_a;
      lo_q   <= acc_is_div ? abs_a : abs_b;
      if (direct) begin
        result_q <= direct_res;
        rd_out_q <= rd_i;
      end
    end else if ((state_q == ST_CALC) && !kill_i) begin
      cnt_q <= cnt_q + 1'b1;
      acc_q <= step_acc;
      lo_q  <= step_lo;
      if (last_iter) begin
        result_q <= calc_res;
        rd_out_q <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit; honours FAST_MUL_EN
// for the expected MUL latency.
module tb_ex_muldiv_unit;

`ifdef FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk, rst, start_i, kill_i;
  logic [2:0]  fnc3_i;
  logic [31:0] op_a_i, op_b_i;
  logic [4:0]  rd_i;
  logic        stall_o, result_valid_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .fnc3_i         (fnc3_i),
    .op_a_i         (op_a_i),
    .op_b_i         (op_b_i),
    .rd_i           (rd_i),
    .kill_i         (kill_i),
    .stall_o        (stall_o),
    .result_valid_o (result_valid_o),
    .result_o       (result_o),
    .rd_o           (rd_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive an op at a negedge (cycle 0), then follow it to its result pulse.
  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input int lat);
    int  cyc;
    bit  stall_ok;
    cyc      = 0;
    stall_ok = 1'b1;
    @(negedge clk);
    start_i = 1'b1; fnc3_i = f; op_a_i = a; op_b_i = b; rd_i = rd;
    #1;
    check({tag, "_stall_c0"}, 32'(stall_o), 32'd1);
    while (1) begin
      @(negedge clk);
      cyc++;
      if (result_valid_o || cyc >= 100) break;
      if (!stall_o) stall_ok = 1'b0;
    end
    check({tag, "_valid"}, 32'(result_valid_o), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(lat));
    check({tag, "_result"}, result_o, exp);
    check({tag, "_rd"}, 32'(rd_o), 32'(rd));
    check({tag, "_stall_held"}, 32'(stall_ok), 32'd1);
    check({tag, "_stall_done"}, 32'(stall_o), 32'd0);
    start_i = 1'b0;
    @(negedge clk);
    check({tag, "_pulse_end"}, 32'(result_valid_o), 32'd0);
    check({tag, "_hold"}, result_o, exp);
  endtask

  initial begin
    int pulses;
    int cyc;
    int second_cyc;

    rst = 1'b1; start_i = 1'b0; kill_i = 1'b0;
    fnc3_i = 3'b000; op_a_i = '0; op_b_i = '0; rd_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_stall", 32'(stall_o), 32'd0);
    check("reset_valid", 32'(result_valid_o), 32'd0);
    check("reset_result", result_o, 32'd0);
    check("reset_rd", 32'(rd_o), 32'd0);

    // Multiplies
    do_op("mul_7x-3",     3'b000, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, MUL_LAT);
    do_op("mulhu_ffff",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, MUL_LAT);
    do_op("mulh_ffff",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, MUL_LAT);
    do_op("mulhsu_ffff",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, MUL_LAT);

    // Divides and remainders
    do_op("div_-20_6",    3'b100, 32'hFFFF_FFEC, 32'd6, 5'd9,  32'hFFFF_FFFD, DIV_LAT);
    do_op("rem_-20_6",    3'b110, 32'hFFFF_FFEC, 32'd6, 5'd10, 32'hFFFF_FFFE, DIV_LAT);
    do_op("divu_100_7",   3'b101, 32'd100,       32'd7, 5'd11, 32'd14,        DIV_LAT);
    do_op("remu_100_7",   3'b111, 32'd100,       32'd7, 5'd12, 32'd2,         DIV_LAT);

    // Special cases resolve in one cycle
    do_op("div_by_0",     3'b100, 32'd1234,      32'd0,         5'd13, 32'hFFFF_FFFF, 1);
    do_op("remu_by_0",    3'b111, 32'd5,         32'd0,         5'd14, 32'd5,         1);
    do_op("div_ovf",      3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1);
    do_op("rem_ovf",      3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         1);

    // Kill at cycle 10 of a DIVU
    @(negedge clk);
    start_i = 1'b1; fnc3_i = 3'b101; op_a_i = 32'd999; op_b_i = 32'd3; rd_i = 5'd20;
    repeat (10) @(negedge clk);
    kill_i = 1'b1; start_i = 1'b0;
    #1;
    check("kill_stall", 32'(stall_o), 32'd0);
    check("kill_valid", 32'(result_valid_o), 32'd0);
    @(negedge clk);
    kill_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_valid_o) pulses++;
    end
    check("kill_no_pulse", 32'(pulses), 32'd0);
    check("kill_idle_stall", 32'(stall_o), 32'd0);
    check("kill_result_held", result_o, 32'd0);
    check("kill_rd_held", 32'(rd_o), 32'd16);
    do_op("after_kill_divu", 3'b101, 32'd100, 32'd7, 5'd21, 32'd14, DIV_LAT);

    // Back-to-back DIV then MUL with start_i held high throughout
    @(negedge clk);
    start_i = 1'b1; fnc3_i = 3'b100; op_a_i = 32'd100; op_b_i = 32'hFFFF_FFF9; rd_i = 5'd3;
    pulses = 0; second_cyc = 0;
    for (cyc = 1; cyc <= 90; cyc++) begin
      @(negedge clk);
      if (result_valid_o) begin
        pulses++;
        if (pulses == 1) begin
          check("b2b_div_cycle", 32'(cyc), 32'(DIV_LAT));
          check("b2b_div_result", result_o, 32'hFFFF_FFF2);
          check("b2b_div_rd", 32'(rd_o), 32'd3);
          fnc3_i = 3'b000; op_a_i = 32'd6; op_b_i = 32'd7; rd_i = 5'd4;
        end else if (pulses == 2) begin
          second_cyc = cyc;
          check("b2b_mul_result", result_o, 32'd42);
          check("b2b_mul_rd", 32'(rd_o), 32'd4);
          start_i = 1'b0;
        end
      end
    end
    check("b2b_pulse_count", 32'(pulses), 32'd2);
    check("b2b_mul_cycle", 32'(second_cyc), 32'(DIV_LAT + 1 + MUL_LAT));

    // Synchronous reset mid-operation aborts without a result
    @(negedge clk);
    start_i = 1'b1; fnc3_i = 3'b101; op_a_i = 32'd50; op_b_i = 32'd5; rd_i = 5'd30;
    repeat (5) @(negedge clk);
    rst = 1'b1; start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_stall", 32'(stall_o), 32'd0);
    check("rst_mid_result", result_o, 32'd0);
    check("rst_mid_rd", 32'(rd_o), 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_valid_o) pulses++;
    end
    check("rst_mid_no_pulse", 32'(pulses), 32'd0);
    do_op("after_rst_divu", 3'b101, 32'd50, 32'd5, 5'd31, 32'd10, DIV_LAT);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
